// File: rtl/trap_unit.sv
// Trap/mret sequencer driving the CSR file's implicit read/write lanes.
// Optional vectored interrupt dispatch: define TRAP_VECTORED_EN.
module trap_unit #(
  parameter logic [1:0] RESET_MODE = 2'b11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         trap_req,
  input  logic [31:0]  trap_cause,
  input  logic [31:0]  trap_pc,
  input  logic [31:0]  trap_tval,
  input  logic         mret_req,
  input  logic [127:0] impl_csr,
  output logic [47:0]  impl_addrs_r,
  output logic [3:0]   impl_read_enable,
  output logic [47:0]  impl_addrs_w,
  output logic [3:0]   impl_write_enable,
  output logic [127:0] impl_write_data,
  output logic [1:0]   mode,
  output logic         busy,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_REDIR
  } state_t;

  typedef enum logic {
    K_TRAP,
    K_MRET
  } kind_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] vec_q, vec_d;
  logic [31:0] mstat_q, mstat_d;
  logic [1:0]  mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic [31:0] base;
  logic [31:0] target;
  logic [31:0] mstat_trap;
  logic [31:0] mstat_mret;

  logic unused_ok;
  assign unused_ok = ^{impl_csr[127:64], pc_q[1:0]};

  always_comb begin
    base   = {vec_q[31:2], 2'b00};
    target = base;
`ifdef TRAP_VECTORED_EN
    // only interrupts dispatch through the table; modes 10/11 act as direct
    if (vec_q[1:0] == 2'b01 && cause_q[31])
      target = base + {cause_q[29:0], 2'b00};
`endif
  end

  always_comb begin
    mstat_trap        = mstat_q;
    mstat_trap[7]     = mstat_q[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = mode_q;
    mstat_mret        = mstat_q;
    mstat_mret[3]     = mstat_q[7];
    mstat_mret[7]     = 1'b1;
    mstat_mret[12:11] = 2'b00;
  end

  always_comb begin
    state_d           = state_q;
    kind_d            = kind_q;
    cause_d           = cause_q;
    pc_d              = pc_q;
    tval_d            = tval_q;
    vec_d             = vec_q;
    mstat_d           = mstat_q;
    mode_d            = mode_q;
    rv_d              = 1'b0;
    rpc_d             = 32'h0;
    impl_addrs_r      = 48'h0;
    impl_read_enable  = 4'b0000;
    impl_addrs_w      = 48'h0;
    impl_write_enable = 4'b0000;
    impl_write_data   = 128'h0;
    unique case (state_q)
      S_IDLE: begin
        if (trap_req) begin
          state_d = S_READ;
          kind_d  = K_TRAP;
          cause_d = trap_cause;
          pc_d    = trap_pc;
          tval_d  = trap_tval;
        end else if (mret_req) begin
          state_d = S_READ;
          kind_d  = K_MRET;
        end
      end
      S_READ: begin
        impl_addrs_r[11:0]  =
          (kind_q == K_TRAP) ? A_MTVEC : A_MEPC;
        impl_addrs_r[23:12] = A_MSTATUS;
        impl_read_enable    = 4'b0011;
        vec_d               = impl_csr[31:0];
        mstat_d             = impl_csr[63:32];
        state_d             = S_WRITE;
      end
      S_WRITE: begin
        rv_d    = 1'b1;
        state_d = S_REDIR;
        if (kind_q == K_TRAP) begin
          impl_write_enable = 4'b1111;
          impl_addrs_w      =
            {A_MSTATUS, A_MTVAL, A_MCAUSE, A_MEPC};
          impl_write_data   = {mstat_trap, tval_q, cause_q,
                               pc_q[31:2], 2'b00};
          mode_d            = 2'b11;
          rpc_d             = target;
        end else begin
          impl_write_enable      = 4'b1000;
          impl_addrs_w[47:36]    = A_MSTATUS;
          impl_write_data[127:96] = mstat_mret;
          mode_d                 = mstat_q[12:11];
          rpc_d                  = vec_q;
        end
      end
      S_REDIR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_TRAP;
      cause_q <= 32'h0;
      pc_q    <= 32'h0;
      tval_q  <= 32'h0;
      vec_q   <= 32'h0;
      mstat_q <= 32'h0;
      mode_q  <= RESET_MODE;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      vec_q   <= vec_d;
      mstat_q <= mstat_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  assign mode           = mode_q;
  assign busy           = busy_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule
